// File: rtl/core_mdu_ctrl.sv
// core_mdu_ctrl -- iterative multiply/divide sequencer for the EX stage.
//
// Takes one MUL or DIV request. It then runs DATA_W steps of a radix-2
// shift-add multiply or a restoring divide. While the op is in flight it
// holds EX through halt_req. The result is presented for one cycle (done)
// so that EX can write it back.
//
// Optional feature: define CORE_MDU_SIGNED_EN to enable signed ops through
// op[1]. Signed operands are converted to magnitudes at start, and the
// sign is fixed in the final step. Without the macro, op[1] is ignored and
// all ops are unsigned.
//
// Ports:
//   clk, rst      core clock; asynchronous active-high reset
//   start         request; op/opa/opb valid this cycle
//   op[0]         0=MUL 1=DIV; op[1] signed (CORE_MDU_SIGNED_EN only)
//   opa, opb      multiplicand/dividend, multiplier/divisor
//   flush         abort the in-flight op
//   halt_req      start | running (combinational, drives ex_halt)
//   busy          running
//   done          result valid, one cycle
//   result        low product / quotient
//   remainder     DIV remainder, 0 for MUL
//   div_zero      DIV by zero, qualified by done
module core_mdu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              flush,
  output logic              halt_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero
);
  localparam int W     = DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, dz_q, div_zero_q;
  logic [W-1:0]     a_q;        // multiplicand (MUL) or divisor (DIV), magnitude
  logic [2*W-1:0]   acc_q;      // MUL: {product hi, multiplier}; DIV: low half = dividend/quotient
  logic [W-1:0]     rem_q;      // DIV partial remainder (always < divisor)
  logic [W-1:0]     result_q, remainder_q;

  // Operand preparation at start
  logic [W-1:0] mag_a, mag_b;
`ifdef CORE_MDU_SIGNED_EN
  logic neg_res_q, neg_rem_q;
  logic sa, sb;
  assign sa    = op[1] & opa[W-1];
  assign sb    = op[1] & opb[W-1];
  assign mag_a = sa ? -opa : opa;
  assign mag_b = sb ? -opb : opb;
`else
  logic unused_sgn;
  assign unused_sgn = op[1];
  assign mag_a      = opa;
  assign mag_b      = opb;
`endif

  // One iteration of each datapath
  logic [W:0]     mul_sum, div_sh;
  logic [2*W-1:0] mul_nxt;
  logic           div_ge;
  logic [W-1:0]   div_rem_nxt, div_q_nxt;
  logic [W-1:0]   fin_res, fin_rem, dz_rem;

  always_comb begin
    mul_sum     = {1'b0, acc_q[2*W-1:W]} + ({1'b0, a_q} & {(W+1){acc_q[0]}});
    mul_nxt     = {mul_sum, acc_q[W-1:1]};
    // Trial subtract: shift next dividend bit into the partial remainder
    div_sh      = {rem_q, acc_q[W-1]};
    div_ge      = div_sh >= {1'b0, a_q};
    div_rem_nxt = div_ge ? W'(div_sh - {1'b0, a_q}) : div_sh[W-1:0];
    div_q_nxt   = {acc_q[W-2:0], div_ge};
    fin_res     = is_div_q ? div_q_nxt : mul_nxt[W-1:0];
    fin_rem     = is_div_q ? div_rem_nxt : '0;
    dz_rem      = acc_q[W-1:0];
`ifdef CORE_MDU_SIGNED_EN
    // Magnitude results are below 2^W, so MIN/-1 wraps to MIN naturally
    if (neg_res_q) fin_res = -fin_res;
    if (neg_rem_q) begin
      fin_rem = -fin_rem;
      dz_rem  = -dz_rem;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      dz_q        <= 1'b0;
      div_zero_q  <= 1'b0;
      a_q         <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
`ifdef CORE_MDU_SIGNED_EN
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      div_zero_q <= 1'b0;  // only ever high during the single DONE cycle
      case (state_q)
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (dz_q) begin
            state_q     <= S_DONE;
            result_q    <= '1;
            remainder_q <= dz_rem;
            div_zero_q  <= 1'b1;
          end else begin
            acc_q <= is_div_q ? {acc_q[2*W-1:W], div_q_nxt} : mul_nxt;
            rem_q <= div_rem_nxt;
            if (cnt_q == LAST) begin
              cnt_q       <= '0;
              state_q     <= S_DONE;
              result_q    <= fin_res;
              remainder_q <= fin_rem;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin  // IDLE and DONE both accept a new request
          if (start && !flush) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            is_div_q <= op[0];
            dz_q     <= op[0] && (opb == '0);
            rem_q    <= '0;
            a_q      <= op[0] ? mag_b : mag_a;
            acc_q    <= {{W{1'b0}}, (op[0] ? mag_a : mag_b)};
`ifdef CORE_MDU_SIGNED_EN
            neg_res_q <= sa ^ sb;
            neg_rem_q <= op[0] & sa;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign halt_req  = start | busy;
  assign result    = result_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
endmodule
